// File: rtl/sad_best_match_if.sv
// Handshake bundle between the search controller, the SAD datapath and the upstream controller.
// slave = search controller side, master = stimulus/upstream side.
interface sad_best_match_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic                 init;
    logic                 ack;
    logic                 sad_done;
    logic [WIDTH+4:0]     sad_value;
    logic                 sad_init;
    logic                 sad_ack;
    logic [IDX_W-1:0]     cand_idx;
    logic [WIDTH+4:0]     best_sad;
    logic [IDX_W-1:0]     best_idx;
    logic                 busy;
    logic                 done;

    modport slave (
        input  init, ack, sad_done, sad_value,
        output sad_init, sad_ack, cand_idx, best_sad, best_idx, busy, done
    );

    modport master (
        output init, ack, sad_done, sad_value,
        input  sad_init, sad_ack, cand_idx, best_sad, best_idx, busy, done
    );
endinterface

// File: rtl/sad_best_match.sv
// Sequences N_CAND candidates through the SAD unit and tracks the minimum SAD and its index.
// Per candidate 1 + W + 1 + A cycles; stalls in WAIT/ACKW on sad_done, holds result in DONE until ack.
module sad_best_match #(
    parameter int WIDTH  = 8,
    parameter int N_CAND = 16,
    parameter int IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sad_best_match_if.slave      bus
);
    localparam int SW = WIDTH + 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_ACKW = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_cand_idx;
    logic [IDX_W-1:0]  w_cand_nxt;
    logic [SW-1:0]     r_best_sad;
    logic [SW-1:0]     w_best_sad_nxt;
    logic [IDX_W-1:0]  r_best_idx;
    logic [IDX_W-1:0]  w_best_idx_nxt;
    logic              r_sad_init;
    logic              r_sad_ack;
    logic              r_busy;
    logic              r_done;

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand_idx;
        w_best_sad_nxt = r_best_sad;
        w_best_idx_nxt = r_best_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.init) begin
                    w_state_nxt    = S_REQ;
                    w_cand_nxt     = '0;
                    w_best_sad_nxt = '1;
                    w_best_idx_nxt = '0;
                end
            end
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.sad_done) w_state_nxt = S_CAP;
            end
            S_CAP: begin
                // strict compare: ties keep the earliest candidate
                if (bus.sad_value < r_best_sad) begin
                    w_best_sad_nxt = bus.sad_value;
                    w_best_idx_nxt = r_cand_idx;
                end
                w_state_nxt = S_ACKW;
            end
            S_ACKW: begin
                if (!bus.sad_done) begin
                    if (r_cand_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cand_nxt  = r_cand_idx + IDX_W'(1);
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_DONE: begin
                if (bus.ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cand_idx <= '0;
            r_best_sad <= '0;
            r_best_idx <= '0;
            r_sad_init <= 1'b0;
            r_sad_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cand_idx <= w_cand_nxt;
            r_best_sad <= w_best_sad_nxt;
            r_best_idx <= w_best_idx_nxt;
            r_sad_init <= (w_state_nxt == S_REQ);
            r_sad_ack  <= (w_state_nxt == S_ACKW);
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.sad_init = r_sad_init;
    assign bus.sad_ack  = r_sad_ack;
    assign bus.cand_idx = r_cand_idx;
    assign bus.best_sad = r_best_sad;
    assign bus.best_idx = r_best_idx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_sad_best_match.sv
// Bench for sad_best_match: table vectors, random searches against a min-search reference,
// and hand sequences for reset, ignored init/ack and back-to-back searches.
module tb_sad_best_match;
    localparam int W  = 8;
    localparam int NC = 4;
    localparam int IW = 4;
    localparam int SW = W + 5;

    typedef logic [NC-1:0][SW-1:0] vals_t;

    typedef struct packed {
        vals_t           v;
        logic [SW-1:0]   exp_sad;
        logic [IW-1:0]   exp_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sad_best_match_if #(.WIDTH(W), .IDX_W(IW)) ifc ();

    sad_best_match #(.WIDTH(W), .N_CAND(NC), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [SW-1:0]  cand_vals [16];
    logic [IW-1:0]  seen_idx [$];
    bit             m_hold = 1'b0;
    int             m_stray = 0;
    int             m_ph = 0;
    int             m_cnt = 0;
    int             pulses = 0;
    int             hi_cycles = 0;
    logic           prev_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain minimum search, earliest index wins on ties.
    function automatic void ref_best(input vals_t v, output logic [SW-1:0] bs, output logic [IW-1:0] bi);
        bs = v[0];
        bi = '0;
        for (int i = 1; i < NC; i++) begin
            if (v[i] < bs) begin
                bs = v[i];
                bi = IW'(i);
            end
        end
    endfunction

    // sad_init pulse accounting
    initial begin
        forever begin
            @(negedge clk);
            if (ifc.sad_init === 1'b1) begin
                hi_cycles++;
                if (!prev_init) pulses++;
            end
            prev_init = (ifc.sad_init === 1'b1);
        end
    end

    // SAD unit model: variable latency to done, 1-3 cycle delayed done release after sad_ack
    initial begin
        ifc.sad_done  = 1'b0;
        ifc.sad_value = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ph = 0;
                ifc.sad_done = 1'b0;
            end else begin
                case (m_ph)
                    0: if (ifc.sad_init === 1'b1) begin
                        seen_idx.push_back(ifc.cand_idx);
                        ifc.sad_value = cand_vals[ifc.cand_idx];
                        m_cnt = $urandom_range(0, 5);
                        if (m_cnt == 0 && !m_hold) begin
                            ifc.sad_done = 1'b1;
                            m_ph = 2;
                        end else begin
                            m_ph = 1;
                        end
                    end
                    1: begin
                        if (ifc.sad_init === 1'b1) m_stray++;
                        if (!m_hold) begin
                            m_cnt--;
                            if (m_cnt <= 0) begin
                                ifc.sad_done = 1'b1;
                                m_ph = 2;
                            end
                        end
                    end
                    2: begin
                        if (ifc.sad_init === 1'b1) m_stray++;
                        if (ifc.sad_ack === 1'b1) begin
                            m_cnt = $urandom_range(1, 3);
                            m_ph = 3;
                        end
                    end
                    default: begin
                        if (ifc.sad_init === 1'b1) m_stray++;
                        if (ifc.sad_ack !== 1'b1) m_stray++;
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            ifc.sad_done = 1'b0;
                            m_ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic run_search(input string tag, input vals_t v, input logic [SW-1:0] es,
                              input logic [IW-1:0] ei, input bit glitch, input bit do_ack);
        int  p0, h0, k;
        bit  order_ok;
        for (int i = 0; i < NC; i++) cand_vals[i] = v[i];
        seen_idx.delete();
        p0 = pulses;
        h0 = hi_cycles;
        ifc.init = 1'b1;
        @(negedge clk);
        ifc.init = 1'b0;
        chk({tag, " req_busy"}, ifc.busy, 1);
        chk({tag, " req_sad_init"}, ifc.sad_init, 1);
        if (glitch) begin
            repeat (2) @(negedge clk);
            ifc.init = 1'b1;
            @(negedge clk);
            ifc.init = 1'b0;
            ifc.ack  = 1'b1;
            repeat (3) @(negedge clk);
            ifc.ack  = 1'b0;
            chk({tag, " ack_early_ignored"}, ifc.done, 0);
        end
        k = 0;
        while (ifc.done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done"}, ifc.done, 1);
        chk({tag, " best_sad"}, ifc.best_sad, es);
        chk({tag, " best_idx"}, ifc.best_idx, ei);
        chk({tag, " cand_idx"}, ifc.cand_idx, NC - 1);
        chk({tag, " busy_in_done"}, ifc.busy, 0);
        chk({tag, " init_pulses"}, pulses - p0, NC);
        chk({tag, " init_cycles"}, hi_cycles - h0, NC);
        order_ok = (seen_idx.size() == NC);
        for (int i = 0; i < seen_idx.size() && i < NC; i++)
            if (seen_idx[i] !== IW'(i)) order_ok = 1'b0;
        chk({tag, " cand_order"}, order_ok, 1);
        if (do_ack) begin
            ifc.ack = 1'b1;
            @(negedge clk);
            ifc.ack = 1'b0;
            chk({tag, " done_fall"}, ifc.done, 0);
        end
    endtask

    vec_t tbl [5];

    initial begin
        vals_t          rv;
        logic [SW-1:0]  rs;
        logic [IW-1:0]  ri;
        int             p0;

        tbl[0] = '{v: {13'd700, 13'd300, 13'd300, 13'd500}, exp_sad: 13'd300,  exp_idx: 4'd1};
        tbl[1] = '{v: {13'd0,   13'd10,  13'd800, 13'd900}, exp_sad: 13'd0,    exp_idx: 4'd3};
        tbl[2] = '{v: {13'd8160, 13'd8160, 13'd8160, 13'd8160}, exp_sad: 13'd8160, exp_idx: 4'd0};
        tbl[3] = '{v: {13'd1,   13'd3,   13'd3,   13'd7},   exp_sad: 13'd1,    exp_idx: 4'd3};
        tbl[4] = '{v: {13'd0,   13'd0,   13'd0,   13'd0},   exp_sad: 13'd0,    exp_idx: 4'd0};

        rst = 1'b1;
        ifc.init = 1'b0;
        ifc.ack  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst sad_init", ifc.sad_init, 0);
        chk("rst sad_ack",  ifc.sad_ack, 0);
        chk("rst busy",     ifc.busy, 0);
        chk("rst done",     ifc.done, 0);
        chk("rst cand_idx", ifc.cand_idx, 0);
        chk("rst best_sad", ifc.best_sad, 0);
        chk("rst best_idx", ifc.best_idx, 0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back: each search starts the cycle after the previous ack
        for (int t = 0; t < 5; t++)
            run_search($sformatf("tbl%0d", t), tbl[t].v, tbl[t].exp_sad, tbl[t].exp_idx, 1'b0, 1'b1);

        run_search("glitch", tbl[0].v, tbl[0].exp_sad, tbl[0].exp_idx, 1'b1, 1'b1);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NC; i++)
                rv[i] = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 8160))
                                                     : SW'(100 * $urandom_range(0, 3));
            ref_best(rv, rs, ri);
            run_search($sformatf("rnd%0d", t), rv, rs, ri, 1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // ack and init together in DONE: return to IDLE only
        run_search("ackinit", tbl[1].v, tbl[1].exp_sad, tbl[1].exp_idx, 1'b0, 1'b0);
        ifc.ack  = 1'b1;
        ifc.init = 1'b1;
        @(negedge clk);
        ifc.ack  = 1'b0;
        ifc.init = 1'b0;
        chk("ackinit done", ifc.done, 0);
        chk("ackinit busy", ifc.busy, 0);
        p0 = pulses;
        repeat (5) @(negedge clk);
        chk("ackinit no_new_search", pulses - p0, 0);
        chk("ackinit idle_busy", ifc.busy, 0);

        // reset in the middle of WAIT
        m_hold = 1'b1;
        for (int i = 0; i < NC; i++) cand_vals[i] = 13'd42;
        ifc.init = 1'b1;
        @(negedge clk);
        ifc.init = 1'b0;
        repeat (4) @(negedge clk);
        chk("midwait busy", ifc.busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_hold = 1'b0;
        chk("midrst busy",     ifc.busy, 0);
        chk("midrst done",     ifc.done, 0);
        chk("midrst sad_init", ifc.sad_init, 0);
        chk("midrst sad_ack",  ifc.sad_ack, 0);
        chk("midrst cand_idx", ifc.cand_idx, 0);
        chk("midrst best_sad", ifc.best_sad, 0);
        chk("midrst best_idx", ifc.best_idx, 0);
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("midrst no_init", pulses - p0, 0);

        run_search("recover", tbl[3].v, tbl[3].exp_sad, tbl[3].exp_idx, 1'b0, 1'b1);
        chk("handshake_protocol", m_stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
